// File: rtl/ram_stack_ctrl.sv
// ram_stack_ctrl: LIFO stack controller driving an external single-cycle
// registered-read RAM. The stack pointer sp equals the number of held words,
// so the top of stack lives at RAM address sp-1 and the next free slot at sp.
//
// Request semantics (no backpressure handshake; requests are accepted or
// refused in the same cycle they are presented):
//   pop_acc  = pop  & ~empty
//   push_acc = push & (~full | pop_acc)
// A refused request sets the matching sticky flag (overflow / underflow) and
// is otherwise ignored. pop_valid rises exactly one cycle after each accepted
// pop, when the RAM's registered read data is presented on pop_data.
module ram_stack_ctrl #(
  parameter int DATA_WIDTH = 9,
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_write_addr,
  output logic [ADDR_WIDTH-1:0] ram_read_addr,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  // Stack depth as an sp value: a lone 1 in the top sp bit.
  localparam logic [ADDR_WIDTH:0]   DEPTH    = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0]   SP_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH:0]   sp;
  logic [ADDR_WIDTH:0]   sp_next;
  logic [ADDR_WIDTH-1:0] sp_addr;
  logic [ADDR_WIDTH-1:0] top_addr;
  logic                  pop_acc;
  logic                  push_acc;

  // Status comes only from the registered pointer, never from this cycle's requests.
  assign count    = sp;
  assign empty    = (sp == '0);
  assign full     = (sp == DEPTH);

  // Low address bits of sp: next free slot; one below it: current top.
  assign sp_addr  = sp[ADDR_WIDTH-1:0];
  assign top_addr = sp_addr - ADDR_ONE;

  // Reset wins over any request in the same cycle, so no RAM write and no
  // pointer motion can leak through while rst is high.
  assign pop_acc  = pop & ~empty & ~rst;
  assign push_acc = push & (~full | pop_acc) & ~rst;

  // Popped data is the RAM's registered output, passed straight through.
  assign pop_data = ram_data_out;

  // RAM port drive: a push+pop pair overwrites the top in place; the RAM's
  // read-before-write behaviour returns the old top on the following cycle.
  always_comb begin
    ram_we         = push_acc;
    ram_data_in    = push_data;
    ram_read_addr  = top_addr;
    ram_write_addr = pop_acc ? top_addr : sp_addr;
  end

  // Pointer update: net change is +1 for push only, -1 for pop only, 0 otherwise.
  always_comb begin
    sp_next = sp;
    case ({push_acc, pop_acc})
      2'b10:   sp_next = sp + SP_ONE;
      2'b01:   sp_next = sp - SP_ONE;
      default: sp_next = sp;
    endcase
  end

  // Registered state: pointer, read-valid pipeline bit and sticky error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      sp        <= '0;
      pop_valid <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      pop_valid <= pop_acc;
      if (push && !push_acc) overflow  <= 1'b1;
      if (pop  && !pop_acc)  underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ram_stack_ctrl.sv
// Testbench for ram_stack_ctrl with a small stack (4 words of 9 bits) and a
// behavioural registered-read RAM. A reference model holds the stack as a
// plain queue; directed vectors come from a table, followed by random traffic.
module tb_ram_stack_ctrl;
  localparam int AW    = 2;
  localparam int DW    = 9;
  localparam int DEPTH = 4;

  // ---------------- clock / reset block ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          push = 1'b0;
  logic          pop = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;
  logic          underflow;
  logic          ram_we;
  logic [AW-1:0] ram_write_addr;
  logic [AW-1:0] ram_read_addr;
  logic [DW-1:0] ram_data_in;
  logic [DW-1:0] ram_data_out;

  always #5 clk = ~clk;

  ram_stack_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .push(push), .pop(pop), .push_data(push_data),
    .pop_valid(pop_valid), .pop_data(pop_data), .count(count),
    .empty(empty), .full(full), .overflow(overflow), .underflow(underflow),
    .ram_we(ram_we), .ram_write_addr(ram_write_addr),
    .ram_read_addr(ram_read_addr), .ram_data_in(ram_data_in),
    .ram_data_out(ram_data_out)
  );

  // Behavioural RAM: registered read, read-before-write on the same address.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rd_q;
  assign ram_data_out = rd_q;
  always @(posedge clk) begin
    rd_q <= mem[ram_read_addr];
    if (ram_we) mem[ram_write_addr] <= ram_data_in;
  end

  // ---------------- scoreboard / reference model ----------------
  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] model_q[$];   // stack contents, back = top
  logic [DW-1:0] exp_q[$];     // popped words awaiting pop_valid
  bit            m_ovf = 0;
  bit            m_unf = 0;
  bit            m_pv  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of inputs, checks the combinational RAM port against the
  // model, advances the model, then checks the registered outputs after the edge.
  task automatic step(input bit r, input bit pu, input bit po, input logic [DW-1:0] d);
    int sz;
    bit pop_ok;
    bit push_ok;
    @(negedge clk);
    rst = r; push = pu; pop = po; push_data = d;
    #1;
    sz      = model_q.size();
    pop_ok  = !r && po && (sz > 0);
    push_ok = !r && pu && ((sz < DEPTH) || pop_ok);
    chk("ram_we", 32'(ram_we), 32'(push_ok));
    if (push_ok) begin
      chk("ram_write_addr", 32'(ram_write_addr), pop_ok ? 32'(sz - 1) : 32'(sz));
      chk("ram_data_in", 32'(ram_data_in), 32'(d));
    end
    if (pop_ok) chk("ram_read_addr", 32'(ram_read_addr), 32'(sz - 1));

    if (r) begin
      model_q.delete();
      exp_q.delete();
      m_ovf = 0; m_unf = 0; m_pv = 0;
    end else begin
      if (pu && !push_ok) m_ovf = 1;
      if (po && !pop_ok)  m_unf = 1;
      m_pv = pop_ok;
      if (pop_ok)  exp_q.push_back(model_q.pop_back());
      if (push_ok) model_q.push_back(d);
    end

    @(posedge clk);
    #1;
    chk("count", 32'(count), 32'(model_q.size()));
    chk("empty", 32'(empty), 32'(model_q.size() == 0));
    chk("full", 32'(full), 32'(model_q.size() == DEPTH));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_unf));
    chk("pop_valid", 32'(pop_valid), 32'(m_pv));
    if (m_pv && exp_q.size() > 0) chk("pop_data", 32'(pop_data), 32'(exp_q.pop_front()));
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit            r;
    bit            pu;
    bit            po;
    logic [DW-1:0] d;
    int            e_count;
    bit            e_pv;
    logic [DW-1:0] e_pd;
    bit            e_ovf;
    bit            e_unf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit pu, input bit po, input logic [DW-1:0] d,
                     input int ec, input bit epv, input logic [DW-1:0] epd,
                     input bit eo, input bit eu);
    vec_t v;
    v.r = r; v.pu = pu; v.po = po; v.d = d;
    v.e_count = ec; v.e_pv = epv; v.e_pd = epd; v.e_ovf = eo; v.e_unf = eu;
    vecs.push_back(v);
  endtask

  int bias;

  initial begin
    //   rst push pop data     count pv  pop_data ovf unf
    add(1, 0, 0, 9'h000,     0, 0, 9'h000, 0, 0);   // reset
    add(0, 1, 0, 9'h011,     1, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h022,     2, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h033,     3, 0, 9'h000, 0, 0);
    add(0, 0, 1, 9'h000,     2, 1, 9'h033, 0, 0);   // back-to-back pops
    add(0, 0, 1, 9'h000,     1, 1, 9'h022, 0, 0);
    add(0, 0, 1, 9'h000,     0, 1, 9'h011, 0, 0);
    add(0, 0, 0, 9'h000,     0, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h0A1,     1, 0, 9'h000, 0, 0);   // fill
    add(0, 1, 0, 9'h0A2,     2, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h0A3,     3, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h0A4,     4, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h1FF,     4, 0, 9'h000, 1, 0);   // push when full
    add(0, 0, 1, 9'h000,     3, 1, 9'h0A4, 1, 0);
    add(0, 0, 1, 9'h000,     2, 1, 9'h0A3, 1, 0);
    add(0, 0, 1, 9'h000,     1, 1, 9'h0A2, 1, 0);
    add(0, 0, 1, 9'h000,     0, 1, 9'h0A1, 1, 0);
    add(1, 0, 0, 9'h000,     0, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h005,     1, 0, 9'h000, 0, 0);
    add(0, 1, 1, 9'h0AA,     1, 1, 9'h005, 0, 0);   // simultaneous push+pop
    add(0, 0, 1, 9'h000,     0, 1, 9'h0AA, 0, 0);
    add(0, 0, 1, 9'h000,     0, 0, 9'h000, 0, 1);   // pop when empty
    add(0, 1, 1, 9'h077,     1, 0, 9'h000, 0, 1);   // push+pop when empty
    add(0, 0, 1, 9'h000,     0, 1, 9'h077, 0, 1);
    add(0, 1, 0, 9'h055,     1, 0, 9'h000, 0, 1);
    add(0, 0, 1, 9'h000,     0, 1, 9'h055, 0, 1);   // pop accepted ...
    add(1, 0, 0, 9'h000,     0, 0, 9'h000, 0, 0);   // ... then reset
    add(0, 1, 0, 9'h101,     1, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h102,     2, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h103,     3, 0, 9'h000, 0, 0);
    add(0, 1, 0, 9'h104,     4, 0, 9'h000, 0, 0);
    add(0, 1, 1, 9'h1EE,     4, 1, 9'h104, 0, 0);   // push+pop when full
    add(0, 0, 1, 9'h000,     3, 1, 9'h1EE, 0, 0);
    add(0, 0, 1, 9'h000,     2, 1, 9'h103, 0, 0);

    foreach (vecs[i]) begin
      step(vecs[i].r, vecs[i].pu, vecs[i].po, vecs[i].d);
      chk($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].e_count));
      chk($sformatf("vec%0d_pop_valid", i), 32'(pop_valid), 32'(vecs[i].e_pv));
      chk($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].e_ovf));
      chk($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].e_unf));
      if (vecs[i].e_pv) chk($sformatf("vec%0d_pop_data", i), 32'(pop_data), 32'(vecs[i].e_pd));
    end

    // Hand-written: rst while a push is requested must not write the RAM.
    @(negedge clk);
    rst = 1'b1; push = 1'b1; pop = 1'b1; push_data = 9'h0F0;
    #1;
    chk("rst_blocks_we", 32'(ram_we), 32'd0);
    step(1, 0, 0, 9'h000);

    // Random traffic; push/pop bias shifts every 50 cycles to reach both ends.
    bias = 50;
    for (int n = 0; n < 800; n++) begin
      if (n % 50 == 0) bias = $urandom_range(15, 85);
      step($urandom_range(0, 59) == 0,
           $urandom_range(0, 99) < bias,
           $urandom_range(0, 99) >= bias,
           9'($urandom_range(0, 511)));
    end

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
